// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity-mode codes and the
// default oversampling ratio. Used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  typedef logic [1:0] parity_mode_t;

  localparam parity_mode_t PAR_NONE     = 2'b00;
  localparam parity_mode_t PAR_ODD      = 2'b01;
  localparam parity_mode_t PAR_EVEN     = 2'b10;
  localparam parity_mode_t PAR_NONE_ALT = 2'b11;

  localparam int DEFAULT_OVERSAMPLE = 16;

  // True when the frame carries a parity bit (odd or even mode).
  function automatic logic parity_enabled(parity_mode_t mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_sequencer_if.sv
// Signal bundle between the baud generator / serial line and the receive
// buffer. The master side feeds ticks and the line; the slave side is the
// frame sequencer.
interface uart_rx_sequencer_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
);

  logic                 baudTick;
  logic                 rxIn;
  parity_mode_t         parityMode;
  logic [DATA_BITS-1:0] dataOut;
  logic                 dataValid;
  logic                 parityError;
  logic                 frameError;
  logic                 busy;

  modport master (
    output baudTick, rxIn, parityMode,
    input  dataOut, dataValid, parityError, frameError, busy
  );

  modport slave (
    input  baudTick, rxIn, parityMode,
    output dataOut, dataValid, parityError, frameError, busy
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input. Both flops load
// RESET_VAL on reset so the output starts at the line's idle level.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clock) begin
    if (rst) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive frame sequencer: qualifies the start bit at mid-bit, samples
// each data bit (LSB first), the optional parity bit and the stop bit at the
// middle of their bit periods, and publishes the byte plus error flags with a
// one-clock dataValid pulse. All progress is gated by baudTick.
module uart_rx_sequencer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                clock,
  input  logic                rst,
  uart_rx_sequencer_if.slave  bus
);

  localparam int TW   = $clog2(OVERSAMPLE);
  localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rx_sync;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clock (clock),
    .rst   (rst),
    .d     (bus.rxIn),
    .q     (rx_sync)
  );

  uart_state_e          state_reg,     state_next;
  logic [TW-1:0]        tick_cnt_reg,  tick_cnt_next;
  logic [BW-1:0]        bit_cnt_reg,   bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg_reg, shift_reg_next;
  logic                 par_acc_reg,   par_acc_next;
  parity_mode_t         mode_reg,      mode_next;
  logic [DATA_BITS-1:0] data_out_reg,  data_out_next;
  logic                 valid_reg,     valid_next;
  logic                 par_err_reg,   par_err_next;
  logic                 frame_err_reg, frame_err_next;

  // State, counters, datapath and output registers.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      tick_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      shift_reg_reg <= '0;
      par_acc_reg   <= 1'b0;
      mode_reg      <= PAR_NONE;
      data_out_reg  <= '0;
      valid_reg     <= 1'b0;
      par_err_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tick_cnt_reg  <= tick_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg_reg <= shift_reg_next;
      par_acc_reg   <= par_acc_next;
      mode_reg      <= mode_next;
      data_out_reg  <= data_out_next;
      valid_reg     <= valid_next;
      par_err_reg   <= par_err_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // Next-state logic; nothing moves unless baudTick is high.
  always_comb begin
    state_next     = state_reg;
    tick_cnt_next  = tick_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_reg_next = shift_reg_reg;
    par_acc_next   = par_acc_reg;
    mode_next      = mode_reg;
    data_out_next  = data_out_reg;
    valid_next     = 1'b0;
    par_err_next   = par_err_reg;
    frame_err_next = frame_err_reg;

    if (bus.baudTick) begin
      case (state_reg)
        ST_IDLE: begin
          if (!rx_sync) begin
            state_next    = ST_START;
            tick_cnt_next = '0;
            mode_next     = bus.parityMode;
          end
        end

        ST_START: begin
          if (tick_cnt_reg == HALF_LAST) begin
            tick_cnt_next = '0;
            if (!rx_sync) begin
              state_next   = ST_DATA;
              bit_cnt_next = '0;
              par_acc_next = 1'b0;
            end else begin
              state_next = ST_IDLE;  // false start: line went back high
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + TW'(1);
          end
        end

        ST_DATA: begin
          if (tick_cnt_reg == FULL_LAST) begin
            tick_cnt_next  = '0;
            shift_reg_next = {rx_sync, shift_reg_reg[DATA_BITS-1:1]};
            par_acc_next   = par_acc_reg ^ rx_sync;
            bit_cnt_next   = bit_cnt_reg + BW'(1);
            if (bit_cnt_reg == BIT_LAST) begin
              state_next = parity_enabled(mode_reg) ? ST_PARITY : ST_STOP;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + TW'(1);
          end
        end

        ST_PARITY: begin
          if (tick_cnt_reg == FULL_LAST) begin
            tick_cnt_next = '0;
            par_acc_next  = par_acc_reg ^ rx_sync;
            state_next    = ST_STOP;
          end else begin
            tick_cnt_next = tick_cnt_reg + TW'(1);
          end
        end

        ST_STOP: begin
          if (tick_cnt_reg == FULL_LAST) begin
            // Leave at mid-stop-bit so a following start edge is seen.
            tick_cnt_next  = '0;
            state_next     = ST_IDLE;
            data_out_next  = shift_reg_reg;
            frame_err_next = !rx_sync;
            // par_acc holds XOR of data and parity: even wants 0, odd wants 1.
            par_err_next   = parity_enabled(mode_reg) &&
                             ((mode_reg == PAR_EVEN) ? par_acc_reg : !par_acc_reg);
            valid_next     = 1'b1;
          end else begin
            tick_cnt_next = tick_cnt_reg + TW'(1);
          end
        end

        default: begin
          state_next    = ST_IDLE;
          tick_cnt_next = '0;
        end
      endcase
    end
  end

  assign bus.dataOut     = data_out_reg;
  assign bus.dataValid   = valid_reg;
  assign bus.parityError = par_err_reg;
  assign bus.frameError  = frame_err_reg;
  assign bus.busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Bench for uart_rx_sequencer: drives whole serial frames aligned to the baud
// ticks, predicts each frame's byte, flags and completion tick from the frame
// contents, and checks the outputs on every clock.
module tb_uart_rx_sequencer;
  import uart_pkg::*;

  localparam int DB = 8;
  localparam int OV = 16;

  logic clock = 1'b0;
  logic rst;

  uart_rx_sequencer_if #(.DATA_BITS(DB)) bus ();

  uart_rx_sequencer #(.DATA_BITS(DB), .OVERSAMPLE(OV)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // baudTick: one clock high out of every four.
  initial begin
    bus.baudTick = 1'b0;
    forever begin
      repeat (3) @(posedge clock);
      #1 bus.baudTick = 1'b1;
      @(posedge clock);
      #1 bus.baudTick = 1'b0;
    end
  end

  int tick_count = 0;
  always @(posedge clock) if (bus.baudTick === 1'b1) tick_count <= tick_count + 1;

  typedef struct {
    logic [DB-1:0] data;
    logic          pe;
    logic          fe;
    int            due;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          cur;
  logic [DB-1:0] m_data = '0;
  logic          m_pe = 1'b0;
  logic          m_fe = 1'b0;
  int            checks = 0;
  int            passes = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h required %0h (tick %0d)", name, act, req, tick_count);
  endtask

  // Every clock: a dataValid pulse must match the oldest predicted frame and
  // its completion tick; otherwise the outputs must hold the last frame.
  always @(negedge clock) begin
    if (rst !== 1'b1) begin
      if (bus.dataValid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("valid_without_frame", {31'b0, bus.dataValid}, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("frame_data", {24'b0, bus.dataOut}, {24'b0, cur.data});
          check("frame_parity_err", {31'b0, bus.parityError}, {31'b0, cur.pe});
          check("frame_stop_err", {31'b0, bus.frameError}, {31'b0, cur.fe});
          check("frame_done_tick", 32'(tick_count), 32'(cur.due));
          m_data = cur.data;
          m_pe   = cur.pe;
          m_fe   = cur.fe;
        end
      end else begin
        check("outputs_hold", {22'b0, bus.dataOut, bus.parityError, bus.frameError},
              {22'b0, m_data, m_pe, m_fe});
      end
    end
  end

  // Wait for the next baud tick edge, then step just past it.
  task automatic next_tick();
    do @(posedge clock); while (bus.baudTick !== 1'b1);
    #1;
  endtask

  task automatic ticks(int n);
    repeat (n) next_tick();
  endtask

  task automatic do_reset();
    bus.rxIn = 1'b1;
    rst = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_data = '0;
    m_pe   = 1'b0;
    m_fe   = 1'b0;
    @(negedge clock);
    check("reset_outputs", {20'b0, bus.dataOut, bus.dataValid, bus.parityError,
          bus.frameError, bus.busy}, 32'd0);
  endtask

  // Send one frame starting right after a tick edge. Bit j of the frame
  // (start = 0) occupies OV ticks. abort_bit >= 0 resets the DUT halfway
  // through that data bit instead of finishing the frame.
  task automatic send_frame(logic [DB-1:0] data, logic [1:0] mode, logic pbit,
                            logic stopb, int abort_bit = -1);
    int   n0;
    int   ones;
    logic en;
    logic bad;
    exp_t e;
    bus.parityMode = mode;
    n0   = tick_count;
    en   = (mode == 2'b01) || (mode == 2'b10);
    ones = $countones(data) + int'(pbit);
    bad  = (mode == 2'b01) ? (ones % 2 != 1) : (ones % 2 != 0);
    if (abort_bit < 0) begin
      e.data = data;
      e.pe   = en && bad;
      e.fe   = !stopb;
      e.due  = n0 + 1 + OV / 2 + (DB + (en ? 1 : 0) + 1) * OV;
      exp_q.push_back(e);
    end
    bus.rxIn = 1'b0;
    ticks(2);
    check("busy_in_frame", {31'b0, bus.busy}, 32'd1);
    bus.parityMode = 2'($urandom_range(0, 3));  // must not affect this frame
    ticks(OV - 2);
    for (int i = 0; i < DB; i++) begin
      bus.rxIn = data[i];
      if (i == abort_bit) begin
        ticks(OV / 2);
        do_reset();
        return;
      end
      ticks(OV);
    end
    if (en) begin
      bus.rxIn = pbit;
      ticks(OV);
    end
    bus.rxIn = stopb;
    ticks(OV);
    if (!stopb) begin
      bus.rxIn = 1'b1;
      ticks(OV);  // let the low tail of a bad stop bit die as a false start
    end
    check("busy_after_frame", {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wait_cnt;
    rst = 1'b1;
    bus.rxIn = 1'b1;
    bus.parityMode = 2'b00;
    repeat (5) @(posedge clock);
    #1 rst = 1'b0;
    @(negedge clock);
    check("reset_state", {20'b0, bus.dataOut, bus.dataValid, bus.parityError,
          bus.frameError, bus.busy}, 32'd0);
    next_tick();
    ticks(4);

    // 0x55, no parity
    send_frame(8'h55, 2'b00, 1'b0, 1'b1);
    check("lit_55", {21'b0, bus.dataOut, bus.parityError, bus.frameError, bus.busy},
          {21'b0, 8'h55, 3'b000});

    // 0xA3 even parity: correct bit, then wrong bit
    send_frame(8'hA3, 2'b10, 1'b0, 1'b1);
    check("lit_a3_even_ok", {23'b0, bus.dataOut, bus.parityError}, {23'b0, 8'hA3, 1'b0});
    send_frame(8'hA3, 2'b10, 1'b1, 1'b1);
    check("lit_a3_even_bad", {23'b0, bus.dataOut, bus.parityError}, {23'b0, 8'hA3, 1'b1});

    // odd parity on 0xA3 wants parity bit 1
    send_frame(8'hA3, 2'b01, 1'b1, 1'b1);
    check("lit_a3_odd_ok", {31'b0, bus.parityError}, 32'd0);

    // stop bit 0, then a good frame clears the flag
    send_frame(8'h3C, 2'b00, 1'b0, 1'b0);
    check("lit_3c_frame_err", {23'b0, bus.dataOut, bus.frameError}, {23'b0, 8'h3C, 1'b1});
    send_frame(8'h0F, 2'b00, 1'b0, 1'b1);
    check("lit_0f_clear", {23'b0, bus.dataOut, bus.frameError}, {23'b0, 8'h0F, 1'b0});

    // short low glitch: false start, nothing changes
    bus.rxIn = 1'b0;
    ticks(5);
    bus.rxIn = 1'b1;
    ticks(2 * OV);
    check("glitch_idle", {23'b0, bus.dataOut, bus.busy}, {23'b0, 8'h0F, 1'b0});

    // reset during the 4th data bit, then a clean 0x81
    send_frame(8'hC6, 2'b00, 1'b0, 1'b1, 3);
    ticks(4);
    send_frame(8'h81, 2'b00, 1'b0, 1'b1);
    check("lit_81_after_abort", {24'b0, bus.dataOut}, 32'h81);

    // back-to-back frames, no idle gap
    send_frame(8'h12, 2'b00, 1'b0, 1'b1);
    send_frame(8'h34, 2'b00, 1'b0, 1'b1);
    check("lit_b2b_34", {24'b0, bus.dataOut}, 32'h34);

    // randomized frames
    for (int k = 0; k < 30; k++) begin
      send_frame(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) != 0));
      ticks($urandom_range(0, 4));
    end

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 2000) begin
      @(posedge clock);
      wait_cnt++;
    end
    check("all_frames_delivered", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
